// File: rtl/pokey_aud_pkg.sv
// Shared field positions and widths for the audio channel control stage.
// AUDCn layout: [7:5] distortion, [4] volume-only, [3:0] volume.
package pokey_aud_pkg;
  localparam int DIST_HI     = 7;
  localparam int DIST_SEL    = 6;
  localparam int DIST_PURE   = 5;
  localparam int VOL_ONLY    = 4;
  localparam int VOL_MSB     = 3;
  localparam int VOL_LSB     = 0;

  localparam int AUDCTL_HP13 = 2;
  localparam int AUDCTL_HP24 = 1;

  localparam int VOL_W       = 4;
  localparam int SUM_W       = 6;
  localparam int NUM_CH      = 4;
endpackage

// File: rtl/aud_channel.sv
// One audio channel: AUDC register, distortion flip-flop, optional high-pass
// sampler and the combinational volume mux feeding the top-level output registers.
module aud_channel
  import pokey_aud_pkg::*;
(
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_enp,
  input  logic [7:0]       i_d,
  input  logic             i_wr,
  input  logic             i_timer,
  input  logic             i_partner_timer,
  input  logic             i_hp_en,
  input  logic             i_rst_phase,
  input  logic             i_poly4,
  input  logic             i_poly5,
  input  logic             i_poly9_17,
  output logic             o_ff,
  output logic [VOL_W-1:0] o_vol
);

  logic [7:0] r_audc;
  logic       r_ff;
  logic       r_hp;
  logic       w_ff_next;
  logic       w_eff;

  // The timer update reads r_audc before any same-edge write lands.
  always_comb begin
    w_ff_next = r_ff;
    if (!r_audc[DIST_HI] && !i_poly5) begin
      w_ff_next = r_ff;
    end else if (r_audc[DIST_PURE]) begin
      w_ff_next = ~r_ff;
    end else if (r_audc[DIST_SEL]) begin
      w_ff_next = i_poly4;
    end else begin
      w_ff_next = i_poly9_17;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_audc <= '0;
      r_ff   <= 1'b0;
      r_hp   <= 1'b0;
    end else if (i_enp) begin
      if (i_wr) begin
        r_audc <= i_d;
      end
      if (i_rst_phase) begin
        r_ff <= 1'b0;
        r_hp <= 1'b0;
      end else begin
        if (i_timer) begin
          r_ff <= w_ff_next;
        end
        // hp samples the pre-edge ff, so a coincident own-timer toggle is not seen.
        if (i_partner_timer) begin
          r_hp <= r_ff;
        end
      end
    end
  end

  assign w_eff = i_hp_en ? (r_ff ^ r_hp) : r_ff;
  assign o_ff  = r_ff;
  assign o_vol = (r_audc[VOL_ONLY] || w_eff) ? r_audc[VOL_MSB:VOL_LSB] : '0;

endmodule

// File: rtl/aud_channel_ctrl.sv
// Four-channel audio control: AUDCTL high-pass bits, channel instances,
// and the registered volumes, volume sum and channel flip-flop states.
module aud_channel_ctrl
  import pokey_aud_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enp,
  input  logic [7:0]       D,
  input  logic             Addr1w,
  input  logic             Addr3w,
  input  logic             Addr5w,
  input  logic             Addr7w,
  input  logic             Addr8w,
  input  logic [4:0]       Timer,
  input  logic             rstAudPhase,
  input  logic             poly4,
  input  logic             poly5,
  input  logic             poly9_17,
  output logic [VOL_W-1:0] vol1,
  output logic [VOL_W-1:0] vol2,
  output logic [VOL_W-1:0] vol3,
  output logic [VOL_W-1:0] vol4,
  output logic [SUM_W-1:0] volSum,
  output logic [3:0]       chOut
);

  logic             r_hp13;
  logic             r_hp24;
  logic [VOL_W-1:0] r_vol [NUM_CH];
  logic [SUM_W-1:0] r_vol_sum;
  logic [3:0]       r_ch_out;

  logic [3:0]       w_wr;
  logic [3:0]       w_partner;
  logic [3:0]       w_hp_en;
  logic [3:0]       w_ff;
  logic [VOL_W-1:0] w_vol [NUM_CH];
  logic [SUM_W-1:0] w_sum;
  logic             w_unused_timer0;

  assign w_wr      = {Addr7w, Addr5w, Addr3w, Addr1w};
  // Ch1 is filtered by ch3's timer, ch2 by ch4's; ch3/ch4 are never filtered.
  assign w_partner = {1'b0, 1'b0, Timer[4], Timer[3]};
  assign w_hp_en   = {1'b0, 1'b0, r_hp24, r_hp13};
  assign w_unused_timer0 = Timer[0];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    aud_channel u_ch (
      .clk             (clk),
      .i_reset         (reset),
      .i_enp           (enp),
      .i_d             (D),
      .i_wr            (w_wr[gi]),
      .i_timer         (Timer[gi+1]),
      .i_partner_timer (w_partner[gi]),
      .i_hp_en         (w_hp_en[gi]),
      .i_rst_phase     (rstAudPhase),
      .i_poly4         (poly4),
      .i_poly5         (poly5),
      .i_poly9_17      (poly9_17),
      .o_ff            (w_ff[gi]),
      .o_vol           (w_vol[gi])
    );
  end

  assign w_sum = SUM_W'(w_vol[0]) + SUM_W'(w_vol[1]) + SUM_W'(w_vol[2]) + SUM_W'(w_vol[3]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hp13    <= 1'b0;
      r_hp24    <= 1'b0;
      r_vol_sum <= '0;
      r_ch_out  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_vol[i] <= '0;
      end
    end else if (enp) begin
      if (Addr8w) begin
        r_hp13 <= D[AUDCTL_HP13];
        r_hp24 <= D[AUDCTL_HP24];
      end
      r_vol_sum <= w_sum;
      r_ch_out  <= w_ff;
      for (int i = 0; i < NUM_CH; i++) begin
        r_vol[i] <= w_vol[i];
      end
    end
  end

  assign vol1   = r_vol[0];
  assign vol2   = r_vol[1];
  assign vol3   = r_vol[2];
  assign vol4   = r_vol[3];
  assign volSum = r_vol_sum;
  assign chOut  = r_ch_out;

endmodule

// File: tb/tb_aud_channel_ctrl.sv
// Directed self-checking bench for aud_channel_ctrl; each task drives one
// scenario and compares outputs against hand-computed values.
module tb_aud_channel_ctrl;

  logic       clk;
  logic       reset;
  logic       enp;
  logic [7:0] D;
  logic       Addr1w, Addr3w, Addr5w, Addr7w, Addr8w;
  logic [4:0] Timer;
  logic       rstAudPhase;
  logic       poly4, poly5, poly9_17;
  logic [3:0] vol1, vol2, vol3, vol4;
  logic [5:0] volSum;
  logic [3:0] chOut;

  int checks;
  int failures;

  aud_channel_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enp         (enp),
    .D           (D),
    .Addr1w      (Addr1w),
    .Addr3w      (Addr3w),
    .Addr5w      (Addr5w),
    .Addr7w      (Addr7w),
    .Addr8w      (Addr8w),
    .Timer       (Timer),
    .rstAudPhase (rstAudPhase),
    .poly4       (poly4),
    .poly5       (poly5),
    .poly9_17    (poly9_17),
    .vol1        (vol1),
    .vol2        (vol2),
    .vol3        (vol3),
    .vol4        (vol4),
    .volSum      (volSum),
    .chOut       (chOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enp = 1'b1; D = 8'h00;
    Addr1w = 0; Addr3w = 0; Addr5w = 0; Addr7w = 0; Addr8w = 0;
    Timer = 5'b0; rstAudPhase = 0; poly4 = 0; poly5 = 0; poly9_17 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1; enp = 1'b0; D = 8'hFF; Timer = 5'b11110;
    Addr1w = 1; Addr3w = 1; Addr5w = 1; Addr7w = 1; Addr8w = 1;
    tick();
    checks++;
    if ({vol1, vol2, vol3, vol4} !== 16'h0000) begin
      $display("FAIL reset_vols got=%h want=0000", {vol1, vol2, vol3, vol4}); failures++;
    end
    checks++;
    if (volSum !== 6'd0 || chOut !== 4'b0) begin
      $display("FAIL reset_sum_chout got=%0d/%b want=0/0000", volSum, chOut); failures++;
    end
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({vol1, vol2, vol3, vol4} !== 16'h0000) begin
      $display("FAIL reset_no_write got=%h want=0000", {vol1, vol2, vol3, vol4}); failures++;
    end
  endtask

  task automatic test_tone();
    logic [3:0] exp_v [5];
    exp_v[0] = 4'h0; exp_v[1] = 4'hF; exp_v[2] = 4'h0; exp_v[3] = 4'hF; exp_v[4] = 4'h0;
    do_reset();
    D = 8'hAF; Addr1w = 1; tick(); Addr1w = 0;
    for (int i = 0; i < 5; i++) begin
      Timer = (i < 4) ? 5'b00010 : 5'b00000;
      tick();
      checks++;
      if (vol1 !== exp_v[i] || volSum !== {2'b00, exp_v[i]} || chOut !== {3'b000, exp_v[i][0]}) begin
        $display("FAIL tone_step%0d got vol1=%h sum=%0d ch=%b want vol1=%h sum=%0d ch=%b",
                 i, vol1, volSum, chOut, exp_v[i], exp_v[i], {3'b000, exp_v[i][0]});
        failures++;
      end
    end
    Timer = 0;
  endtask

  task automatic test_write_timer();
    do_reset();
    D = 8'hAF; Addr1w = 1; tick();
    // new value 0x0F would drop the pulse (poly5=0); old 0xAF must toggle
    D = 8'h0F; Timer = 5'b00010; tick();
    Addr1w = 0; Timer = 0; tick();
    checks++;
    if (vol1 !== 4'hF || chOut !== 4'b0001) begin
      $display("FAIL write_timer_old got vol1=%h ch=%b want F/0001", vol1, chOut); failures++;
    end
  endtask

  task automatic test_vol_only();
    do_reset();
    D = 8'h15; Addr3w = 1; tick(); Addr3w = 0;
    checks++;
    if (vol2 !== 4'h0) begin
      $display("FAIL volonly_first got=%h want=0", vol2); failures++;
    end
    tick();
    checks++;
    if (vol2 !== 4'h5 || volSum !== 6'd5) begin
      $display("FAIL volonly_second got vol2=%h sum=%0d want 5/5", vol2, volSum); failures++;
    end
  endtask

  task automatic test_enp_gate();
    do_reset();
    enp = 0; D = 8'h1A; Addr3w = 1; Timer = 5'b11110; poly5 = 1; poly9_17 = 1;
    tick(); tick();
    clear_inputs();
    tick(); tick();
    checks++;
    if (vol2 !== 4'h0 || chOut !== 4'b0) begin
      $display("FAIL enp_gate got vol2=%h ch=%b want 0/0000", vol2, chOut); failures++;
    end
  endtask

  task automatic test_poly();
    do_reset();
    D = 8'h08; Addr5w = 1; tick(); Addr5w = 0;
    poly5 = 0; poly9_17 = 1; Timer = 5'b01000;
    tick(); tick(); tick();
    Timer = 0; tick();
    checks++;
    if (vol3 !== 4'h0 || chOut !== 4'b0000) begin
      $display("FAIL poly5_gate got vol3=%h ch=%b want 0/0000", vol3, chOut); failures++;
    end
    poly5 = 1; Timer = 5'b01000; tick();
    Timer = 0; tick();
    checks++;
    if (vol3 !== 4'h8 || chOut !== 4'b0100 || volSum !== 6'd8) begin
      $display("FAIL poly917 got vol3=%h ch=%b sum=%0d want 8/0100/8", vol3, chOut, volSum); failures++;
    end
    D = 8'hC3; Addr7w = 1; tick(); Addr7w = 0;
    poly4 = 1; poly9_17 = 0; poly5 = 0; Timer = 5'b10000; tick();
    Timer = 0; tick();
    checks++;
    if (vol4 !== 4'h3 || chOut !== 4'b1100 || volSum !== 6'd11) begin
      $display("FAIL poly4 got vol4=%h ch=%b sum=%0d want 3/1100/11", vol4, chOut, volSum); failures++;
    end
  endtask

  task automatic test_highpass();
    do_reset();
    D = 8'h04; Addr8w = 1; tick(); Addr8w = 0;
    D = 8'hA4; Addr1w = 1; Addr5w = 1; tick(); Addr1w = 0; Addr5w = 0;
    Timer = 5'b00010; tick();
    Timer = 5'b01010; tick();
    checks++;
    if (vol1 !== 4'h4) begin
      $display("FAIL hp_edge4 got vol1=%h want 4", vol1); failures++;
    end
    Timer = 5'b00010; tick();
    checks++;
    if (vol1 !== 4'h4 || vol3 !== 4'h4 || volSum !== 6'd8) begin
      $display("FAIL hp_xor got vol1=%h vol3=%h sum=%0d want 4/4/8", vol1, vol3, volSum); failures++;
    end
    Timer = 0; tick();
    checks++;
    if (vol1 !== 4'h0 || volSum !== 6'd4 || chOut !== 4'b0101) begin
      $display("FAIL hp_cancel got vol1=%h sum=%0d ch=%b want 0/4/0101", vol1, volSum, chOut); failures++;
    end
  endtask

  task automatic test_full_and_phase();
    do_reset();
    D = 8'h1F; Addr1w = 1; Addr3w = 1; Addr5w = 1; Addr7w = 1; tick();
    Addr1w = 0; Addr3w = 0; Addr5w = 0; Addr7w = 0; tick();
    checks++;
    if ({vol1, vol2, vol3, vol4} !== 16'hFFFF || volSum !== 6'd60) begin
      $display("FAIL full_vol got=%h sum=%0d want FFFF/60", {vol1, vol2, vol3, vol4}, volSum); failures++;
    end
    poly5 = 1; poly9_17 = 1; Timer = 5'b11110; tick();
    Timer = 0; tick();
    checks++;
    if (chOut !== 4'b1111) begin
      $display("FAIL ff_all_set got=%b want 1111", chOut); failures++;
    end
    rstAudPhase = 1; Timer = 5'b11110; tick();
    rstAudPhase = 0; Timer = 0; tick();
    checks++;
    if (chOut !== 4'b0000 || {vol1, vol2, vol3, vol4} !== 16'hFFFF || volSum !== 6'd60) begin
      $display("FAIL phase_reset got ch=%b vols=%h sum=%0d want 0000/FFFF/60",
               chOut, {vol1, vol2, vol3, vol4}, volSum);
      failures++;
    end
    reset = 1; enp = 0; Addr1w = 1; D = 8'h1F; tick();
    reset = 0; enp = 1; Addr1w = 0;
    checks++;
    if ({vol1, vol2, vol3, vol4} !== 16'h0000 || volSum !== 6'd0) begin
      $display("FAIL midop_reset got vols=%h sum=%0d want 0000/0", {vol1, vol2, vol3, vol4}, volSum); failures++;
    end
    tick();
    checks++;
    if (vol1 !== 4'h0) begin
      $display("FAIL midop_audc_clr got vol1=%h want 0", vol1); failures++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_tone();
    test_write_timer();
    test_vol_only();
    test_enp_gate();
    test_poly();
    test_highpass();
    test_full_and_phase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aud_channel_ctrl.md
# aud_channel_ctrl

Audio channel control stage sitting directly downstream of the frequency control block. Consumes the four per-channel timer pulses, applies per-channel distortion (polynomial gating and sampling), optional high-pass filtering and volume control, and produces four 4-bit channel volumes plus their 6-bit sum for the audio DAC.

## Interface
Parameters:
- none. Channel count is fixed at 4; volume width is fixed at 4 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk, overrides enp
- enp  in  1  clock enable; state advances only on edges where enp=1
- D  in  8  CPU write data bus
- Addr1w, Addr3w, Addr5w, Addr7w  in  1 each  write strobes for AUDC1..AUDC4
- Addr8w  in  1  write strobe for AUDCTL; only bits 2 and 1 are used here
- Timer  in  5  channel underflow pulses; bit i (1..4) is channel i, bit 0 ignored
- rstAudPhase  in  1  phase reset from frequency control (STIMER)
- poly4, poly5, poly9_17  in  1 each  current polynomial counter output bits
- vol1, vol2, vol3, vol4  out  4 each  registered channel volumes
- volSum  out  6  registered sum of vol1..vol4, range 0..60
- chOut  out  4  registered channel output flip-flop states, bit i-1 = channel i

## Operation
- AUDCn register: bits 7:5 distortion, bit 4 volume-only, bits 3:0 volume. AUDCTL bit 2 = high-pass ch1 by ch3; bit 1 = high-pass ch2 by ch4.
- Register writes: on enp edge with strobe high, store D. Write and timer pulse on the same edge: timer update uses the old AUDC value; the new value is effective from the next enp edge.
- Channel flip-flop ffN updates only on an enp edge with Timer[N]=1:
  - AUDC[7]=0 and poly5=0: no update (pulse dropped).
  - Otherwise, AUDC[5]=1: ffN toggles (pure tone).
  - Otherwise, AUDC[6]=1: ffN <= poly4.
  - Otherwise: ffN <= poly9_17.
- High-pass: hp1 <= ff1 on enp edge with Timer[3]=1; hp2 <= ff2 on Timer[4]=1. When the AUDCTL bit is set, the effective output of ch1 is ff1 XOR hp1 (ch2 likewise); otherwise it is ffN. Channels 3 and 4 are never filtered.
- Volume: AUDC[4]=1 gives volN = AUDC[3:0] regardless of ff state. Otherwise volN = effective output ? AUDC[3:0] : 0.
- volSum is the unsigned 6-bit sum of the four next-state volumes. It cannot overflow (max 60).
- rstAudPhase=1 on an enp edge clears ff1..ff4 and hp1, hp2. This takes priority over a simultaneous Timer pulse. AUDC and AUDCTL values are retained.

## Timing
- Reset values: all AUDC=0x00, AUDCTL bits=0, ff/hp=0, vol1..4=0, volSum=0, chOut=0.
- Latency:
  - Timer[N] pulse on enp edge k updates ffN at edge k.
  - volN, volSum and chOut reflect it at edge k+1.
  - The same registered path applies to AUDC writes: a write at edge k first affects vol at edge k+1 (volume-only) or at the next ff update.
- A Timer pulse with enp=0 is ignored. Upstream holds pulses valid for exactly one enp-qualified edge.
- reset mid-operation clears everything on that edge, regardless of enp, Timer or write strobes.
- Simultaneous Timer[1] and Timer[3] with high-pass on: hp1 samples the old ff1, ff1 updates in parallel, and the XOR uses the new values.

## Structure
- Package pokey_aud_pkg holds:
  - AUDC field positions: DIST_HI=7, DIST_SEL=6, DIST_PURE=5, VOL_ONLY=4, VOL msb/lsb.
  - AUDCTL_HP13=2 and AUDCTL_HP24=1.
  - volume width 4, sum width 6.
- Sub-module aud_channel, instantiated 4x: AUDC register, ff update logic and volume mux. It takes the high-pass enable and partner timer as inputs; channels 3/4 tie the enable low.
- The top level holds AUDCTL bits, the sum adder and the output registers.

## Test plan
- After reset, write AUDC1=0xAF, then pulse Timer[1] on 4 enp edges -> ff1 toggles 1,0,1,0; vol1 alternates 0xF/0x0 one edge later; volSum matches.
- AUDC2=0x15, no timer activity -> vol2=5 at the second enp edge after the write; volSum=5.
- AUDC3=0x08 (poly5 gated, poly9_17), poly5=0 with Timer[3] pulses -> ff3 holds. Set poly5=1 and poly9_17=1 -> ff3=1, vol3=8.
- AUDCTL=0x04, AUDC1=AUDC3=0xA4, ch1 pulsing every edge, Timer[3] coincident with the ff1=1 state -> hp1=1, and vol1 follows ff1 XOR hp1.
- Drive all four channels to full volume (0x1F each) -> volSum=60. Assert rstAudPhase together with Timer pulses -> all ff/hp=0, chOut=0, and volume-only channels remain at 15.
